// File: rtl/mem_responder.sv
// mem_responder: load/store responder between a multicycle MIPS datapath and a
// single-port synchronous word RAM without byte enables. It serves LW/LBU/LB/SW/SB.
// Byte stores are done as read-modify-write.
// Optional build macro MEM_RESPONDER_BIG_ENDIAN_EN: byte lanes use big-endian
// ordering (lane = 3 - addr[1:0]). Otherwise the lane mapping is little-endian.
`timescale 1ns/1ps

module mem_responder #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_we,
  input  logic [1:0]    req_ltype,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [31:0]   rsp_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RMW_WR, RESP
  } state_t;

  state_t         state, state_next;

  logic [AW+1:0]  addr_q;    // latched byte address, in-range part only
  logic [1:0]     ltype_q;
  logic [31:0]    data_q;    // store data, becomes the merged word for byte stores
  logic           err_q;
  logic [31:0]    rdata_q;

  logic           req_err;
  logic [1:0]     lane;
  logic [7:0]     sel_byte;
  logic [31:0]    load_word;
  logic [31:0]    merged;
  logic           ram_en_raw;
  logic           ram_we_raw;

`ifdef MEM_RESPONDER_BIG_ENDIAN_EN
  assign lane = 2'd3 - addr_q[1:0];
`else
  assign lane = addr_q[1:0];
`endif

  // Classify the incoming request as illegal: reserved codes, misaligned word access, out of range
  always_comb begin
    req_err = 1'b0;
    if (req_we == 2'b11)
      req_err = 1'b1;
    if (req_we == 2'b00 && req_ltype == 2'b11)
      req_err = 1'b1;
    if ((req_we == 2'b01 || (req_we == 2'b00 && req_ltype == 2'b00)) && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (req_addr[31:AW+2] != '0)
      req_err = 1'b1;
  end

  // Byte-lane extraction, load formatting and byte-store merge on the RAM read word
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_byte  = ram_rdata[7:0];
    merged    = ram_rdata;
    load_word = ram_rdata;
    case (lane)
      2'd0: begin sel_byte = ram_rdata[7:0];   merged[7:0]   = data_q[7:0]; end
      2'd1: begin sel_byte = ram_rdata[15:8];  merged[15:8]  = data_q[7:0]; end
      2'd2: begin sel_byte = ram_rdata[23:16]; merged[23:16] = data_q[7:0]; end
      2'd3: begin sel_byte = ram_rdata[31:24]; merged[31:24] = data_q[7:0]; end
      default: ;
    endcase
    case (ltype_q)
      2'b01:   load_word = {24'h000000, sel_byte};
      2'b10:   load_word = {{24{sel_byte[7]}}, sel_byte};
      default: load_word = ram_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic and state-decoded handshake/RAM strobes
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    ram_en_raw = 1'b0;
    ram_we_raw = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_next = RESP;
          else if (req_we == 2'b00)
            state_next = RD;
          else if (req_we == 2'b01)
            state_next = WR;
          else
            state_next = RMW_RD;
        end
      end
      RD: begin
        ram_en_raw = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT:   state_next = RESP;
      WR: begin
        ram_en_raw = 1'b1;
        ram_we_raw = 1'b1;
        state_next = RESP;
      end
      RMW_RD: begin
        ram_en_raw = 1'b1;
        state_next = RMW_MERGE;
      end
      RMW_MERGE: state_next = RMW_WR;
      RMW_WR: begin
        ram_en_raw = 1'b1;
        ram_we_raw = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = err_q;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // A reset in the same cycle as a pending RAM access suppresses it, so an abandoned write never lands
  assign ram_en    = ram_en_raw & ~reset;
  assign ram_we    = ram_we_raw & ~reset;
  assign ram_addr  = addr_q[AW+1:2];
  assign ram_wdata = data_q;
  assign rsp_rdata = rdata_q;

  // Request capture, load-data formatting and byte-store merge registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      ltype_q <= 2'b00;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr[AW+1:0];
            ltype_q <= req_ltype;
            data_q  <= req_wdata;
            err_q   <= req_err;
            if (req_err)
              rdata_q <= 32'h0;
          end
        end
        RD_WAIT:    rdata_q <= load_word;
        RMW_MERGE:  data_q  <= merged;
        WR, RMW_WR: rdata_q <= 32'h0;
        default: ;
      endcase
    end
  end

endmodule
